// File: rtl/grid_line_clear.sv
// grid_line_clear: bottom-up scan of a row-major byte grid that removes full rows.
// Optional GRID_LC_TOTAL_EN adds a saturating running total of cleared lines.
module grid_line_clear #(
    parameter int NUM_ROWS = 16,
    parameter int NUM_COLS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  lines_cleared,
    output logic [7:0]  mem_addr_a,
    output logic [7:0]  mem_data_a,
    output logic        mem_we_a,
    output logic [7:0]  mem_addr_b,
    input  logic [7:0]  mem_q_b
`ifdef GRID_LC_TOTAL_EN
    ,
    output logic [15:0] total_lines
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SHIFT,
        CLEAR_TOP,
        DONE
    } state_t;

    localparam logic [3:0] TOP_ROW  = 4'(NUM_ROWS - 1);
    localparam logic [4:0] LAST_CNT = 5'(NUM_COLS);
    localparam logic [4:0] LAST_COL = 5'(NUM_COLS - 1);

    state_t     state;
    logic [3:0] row;
    logic [3:0] dst;
    logic [4:0] cnt;
    logic       full_acc;
    logic       q_nz;
    logic       row_full;
    logic [3:0] col_next;

    assign q_nz     = |mem_q_b;
    assign row_full = full_acc & q_nz;
    assign col_next = cnt[3:0] + 4'd1;

    // Shift copies read data straight through; every other write is a clear.
    assign mem_data_a = (state == SHIFT) ? mem_q_b : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            row           <= '0;
            dst           <= '0;
            cnt           <= '0;
            full_acc      <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
            mem_we_a      <= 1'b0;
            mem_addr_a    <= '0;
            mem_addr_b    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    mem_we_a <= 1'b0;
                    done     <= 1'b0;
                    if (start) begin
                        state         <= SCAN;
                        busy          <= 1'b1;
                        lines_cleared <= '0;
                        row           <= TOP_ROW;
                        cnt           <= '0;
                        full_acc      <= 1'b1;
                        mem_addr_b    <= {TOP_ROW, 4'd0};
                    end
                end

                SCAN: begin
                    // Data for column cnt-1 arrives while cnt is presented.
                    if (cnt != 5'd0) begin
                        full_acc <= row_full;
                    end
                    if (cnt != LAST_CNT) begin
                        cnt <= cnt + 5'd1;
                        if (cnt != LAST_COL) begin
                            mem_addr_b <= {row, col_next};
                        end
                    end else begin
                        cnt      <= '0;
                        full_acc <= 1'b1;
                        if (row_full && row != 4'd0) begin
                            state      <= SHIFT;
                            dst        <= row;
                            mem_addr_b <= {row - 4'd1, 4'd0};
                        end else if (row_full) begin
                            state      <= CLEAR_TOP;
                            mem_we_a   <= 1'b1;
                            mem_addr_a <= '0;
                        end else if (row != 4'd0) begin
                            row        <= row - 4'd1;
                            mem_addr_b <= {row - 4'd1, 4'd0};
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end

                SHIFT: begin
                    if (cnt != LAST_CNT) begin
                        cnt        <= cnt + 5'd1;
                        mem_we_a   <= 1'b1;
                        mem_addr_a <= {dst, cnt[3:0]};
                        if (cnt != LAST_COL) begin
                            mem_addr_b <= {dst - 4'd1, col_next};
                        end
                    end else begin
                        cnt <= '0;
                        if (dst != 4'd1) begin
                            dst        <= dst - 4'd1;
                            mem_we_a   <= 1'b0;
                            mem_addr_b <= {dst - 4'd2, 4'd0};
                        end else begin
                            state      <= CLEAR_TOP;
                            mem_we_a   <= 1'b1;
                            mem_addr_a <= '0;
                        end
                    end
                end

                CLEAR_TOP: begin
                    if (cnt != LAST_COL) begin
                        cnt        <= cnt + 5'd1;
                        mem_addr_a <= {4'd0, col_next};
                    end else begin
                        cnt        <= '0;
                        mem_we_a   <= 1'b0;
                        state      <= SCAN;
                        full_acc   <= 1'b1;
                        mem_addr_b <= {row, 4'd0};
                        if (lines_cleared != 5'd31) begin
                            lines_cleared <= lines_cleared + 5'd1;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    mem_we_a <= 1'b0;
                end
            endcase
        end
    end

`ifdef GRID_LC_TOTAL_EN
    logic [16:0] total_sum;

    assign total_sum = {1'b0, total_lines} + 17'(lines_cleared);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_lines <= '0;
        end else if (state == DONE) begin
            total_lines <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
        end
    end
`endif

endmodule
